// File: rtl/strobe_driver.sv
// Command FIFO feeding a setup/pulse/hold strobe sequencer; each pulsed command takes 1+SETUP+PULSE+HOLD cycles.
// Optional downstream shadow-state model enabled by defining STROBE_DRIVER_SHADOW_EN.
module strobe_driver #(
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int HOLD_CYC   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    cmd_data,
    input  logic [1:0]                    cmd_lane,
    output logic [3:0]                    data_out,
    output logic [1:0]                    strobe,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [3:0]                    shadow_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      lane_q, lane_d;
    logic [3:0]      data_q, data_d;
    logic [1:0]      strobe_q, strobe_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [5:0]      mem_q [FIFO_DEPTH];
    logic [5:0]      mem_d [FIFO_DEPTH];
    logic [5:0]      head;
    logic            push, pop;

    assign cmd_ready  = (count_q != CW'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == IDLE) && (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign data_out   = data_q;
    assign strobe     = strobe_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = {cmd_lane, cmd_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                // A lane-00 command is consumed without disturbing the data bus.
                if (pop && (head[5:4] != 2'b00)) begin
                    lane_d  = head[5:4];
                    data_d  = head[3:0];
                    cnt_d   = 4'(SETUP_CYC - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = 4'(PULSE_CYC - 1);
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = 4'(HOLD_CYC - 1);
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
        // Strobe is re-timed one cycle behind the state so it comes straight off a flop.
        strobe_d = (state_q == PULSE) ? lane_q : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lane_q   <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lane_q   <= lane_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

`ifdef STROBE_DRIVER_SHADOW_EN
    logic       pulse_end;
    logic [3:0] shadow_q, shadow_d;

    assign pulse_end = (state_q == PULSE) && (cnt_q == '0);

    always_comb begin
        shadow_d = shadow_q;
        if (pulse_end) begin
            if (lane_q[1]) shadow_d[3:2] = shadow_q[3:2] ^ data_q[3:2];
            if (lane_q[0]) shadow_d[1:0] = shadow_q[1:0] ^ data_q[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow_q <= '0;
        else     shadow_q <= shadow_d;
    end

    assign shadow_state = shadow_q;
`else
    assign shadow_state = 4'h0;
`endif

endmodule

// File: tb/tb_strobe_driver.sv
// Directed self-checking bench for strobe_driver with default parameters.
module tb_strobe_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic [1:0] cmd_lane;
    logic [3:0] data_out;
    logic [1:0] strobe;
    logic       busy;
    logic [2:0] fifo_count;
    logic [3:0] shadow_state;

    int checks = 0;
    int errors = 0;

`ifdef STROBE_DRIVER_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    strobe_driver dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_lane(cmd_lane), .data_out(data_out),
        .strobe(strobe), .busy(busy), .fifo_count(fifo_count),
        .shadow_state(shadow_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = 4'h0; cmd_lane = 2'b00;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = 4'h0; cmd_lane = 2'b00;
        #3;
        checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL rst_data got %h exp 0", data_out); end
        checks++; if (strobe !== 2'b00) begin errors++; $display("FAIL rst_strobe got %b exp 00", strobe); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (shadow_state !== 4'h0) begin errors++; $display("FAIL rst_shadow got %h exp 0", shadow_state); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
    endtask

    task automatic test_single();
        logic [3:0] exp_sh;
        do_reset();
        exp_sh = SH ? 4'hA : 4'h0;
        cmd_valid = 1'b1; cmd_data = 4'hA; cmd_lane = 2'b11;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", cmd_ready); end
        tick();  // edge 0
        cmd_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count0 got %0d exp 1", fifo_count); end
        tick();  // edge 1
        checks++; if (data_out !== 4'hA) begin errors++; $display("FAIL single_data1 got %h exp a", data_out); end
        checks++; if (strobe !== 2'b00) begin errors++; $display("FAIL single_strobe1 got %b exp 00", strobe); end
        tick();  // edge 2
        checks++; if (strobe !== 2'b00) begin errors++; $display("FAIL single_strobe2 got %b exp 00", strobe); end
        tick();  // edge 3
        checks++; if (strobe !== 2'b11) begin errors++; $display("FAIL single_strobe3 got %b exp 11", strobe); end
        tick();  // edge 4
        checks++; if (strobe !== 2'b11) begin errors++; $display("FAIL single_strobe4 got %b exp 11", strobe); end
        tick();  // edge 5
        checks++; if (strobe !== 2'b00) begin errors++; $display("FAIL single_strobe5 got %b exp 00", strobe); end
        tick();  // edge 6
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy6 got %b exp 0", busy); end
        checks++; if (shadow_state !== exp_sh) begin errors++; $display("FAIL single_shadow got %h exp %h", shadow_state, exp_sh); end
        checks++; if (data_out !== 4'hA) begin errors++; $display("FAIL single_data_hold got %h exp a", data_out); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int max_cnt = 0;
        int ready_bad = 0;
        int saw_full = 0;
        logic [1:0] prev_strobe = 2'b00;
        int rise_cyc[$];
        int rise_dat[$];
        int rise_lane[$];
        do_reset();
        for (int c = 0; c < 60; c++) begin
            cmd_valid = (sent < 6);
            cmd_data  = 4'(sent + 1);
            cmd_lane  = 2'((sent % 3) + 1);
            #1;
            if ((fifo_count == 3'd4) && (cmd_ready !== 1'b0)) ready_bad++;
            if ((fifo_count < 3'd4) && (cmd_ready !== 1'b1)) ready_bad++;
            if ((fifo_count == 3'd4) && (cmd_ready === 1'b0)) saw_full = 1;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (cmd_valid && cmd_ready) sent++;
            tick();
            if ((prev_strobe == 2'b00) && (strobe != 2'b00)) begin
                rise_cyc.push_back(c);
                rise_dat.push_back(int'(data_out));
                rise_lane.push_back(int'(strobe));
            end
            prev_strobe = strobe;
        end
        cmd_valid = 1'b0;
        checks++; if (max_cnt != 4) begin errors++; $display("FAIL b2b_max_count got %0d exp 4", max_cnt); end
        checks++; if (saw_full != 1) begin errors++; $display("FAIL b2b_full_seen got %0d exp 1", saw_full); end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL b2b_ready_vs_count got %0d bad exp 0", ready_bad); end
        checks++; if (rise_cyc.size() != 6) begin errors++; $display("FAIL b2b_pulses got %0d exp 6", rise_cyc.size()); end
        for (int i = 0; i < rise_cyc.size(); i++) begin
            checks++;
            if ((rise_dat[i] != i + 1) || (rise_lane[i] != (i % 3) + 1)) begin
                errors++;
                $display("FAIL b2b_order idx %0d got %h/%0d exp %h/%0d", i, rise_dat[i], rise_lane[i], i + 1, (i % 3) + 1);
            end
            if (i > 0) begin
                checks++;
                if (rise_cyc[i] - rise_cyc[i-1] != 5) begin
                    errors++;
                    $display("FAIL b2b_spacing idx %0d got %0d exp 5", i, rise_cyc[i] - rise_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_shadow();
        logic [3:0] dats [3] = '{4'h3, 4'hC, 4'hF};
        logic [1:0] lns  [3] = '{2'b01, 2'b10, 2'b11};
        logic [3:0] exp_seq [3] = '{4'h3, 4'hF, 4'h0};
        logic [3:0] prev = 4'h0;
        logic [3:0] seen[$];
        do_reset();
        for (int c = 0; c < 30; c++) begin
            cmd_valid = (c < 3);
            cmd_data  = (c < 3) ? dats[c] : 4'h0;
            cmd_lane  = (c < 3) ? lns[c] : 2'b00;
            tick();
            if (shadow_state !== prev) seen.push_back(shadow_state);
            prev = shadow_state;
        end
        cmd_valid = 1'b0;
        checks++;
        if (seen.size() != (SH ? 3 : 0)) begin errors++; $display("FAIL shadow_changes got %0d exp %0d", seen.size(), SH ? 3 : 0); end
        for (int i = 0; i < seen.size() && i < 3; i++) begin
            checks++;
            if (seen[i] !== exp_seq[i]) begin errors++; $display("FAIL shadow_seq idx %0d got %h exp %h", i, seen[i], exp_seq[i]); end
        end
    endtask

    task automatic test_lane_zero();
        int bad = 0;
        do_reset();
        cmd_valid = 1'b1; cmd_data = 4'h9; cmd_lane = 2'b10;
        tick();
        cmd_valid = 1'b0;
        repeat (7) tick();
        checks++; if (data_out !== 4'h9) begin errors++; $display("FAIL lz_preload got %h exp 9", data_out); end
        cmd_valid = 1'b1; cmd_data = 4'h5; cmd_lane = 2'b00;
        tick();
        cmd_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL lz_count0 got %0d exp 1", fifo_count); end
        for (int c = 0; c < 6; c++) begin
            tick();
            if ((strobe !== 2'b00) || (data_out !== 4'h9)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL lz_quiet got %0d bad cycles exp 0", bad); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL lz_count_end got %0d exp 0", fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lz_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid_pulse();
        logic [3:0] exp_sh;
        exp_sh = SH ? 4'hA : 4'h0;
        do_reset();
        cmd_valid = 1'b1; cmd_data = 4'hA; cmd_lane = 2'b11;
        tick();  // edge 0
        cmd_data = 4'h6; cmd_lane = 2'b01;
        tick();  // edge 1
        cmd_valid = 1'b0;
        repeat (2) tick();  // edges 2, 3
        checks++; if (strobe !== 2'b11) begin errors++; $display("FAIL rmp_pulse got %b exp 11", strobe); end
        #2 rst = 1'b1;
        #1;
        checks++; if (strobe !== 2'b00) begin errors++; $display("FAIL rmp_strobe got %b exp 00", strobe); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmp_count got %0d exp 0", fifo_count); end
        checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL rmp_data got %h exp 0", data_out); end
        checks++; if (shadow_state !== 4'h0) begin errors++; $display("FAIL rmp_shadow got %h exp 0", shadow_state); end
        tick();
        rst = 1'b0;
        cmd_valid = 1'b1; cmd_data = 4'hA; cmd_lane = 2'b11;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmp_ready got %b exp 1", cmd_ready); end
        tick();  // edge 0
        cmd_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL rmp_accept got %0d exp 1", fifo_count); end
        tick();  // edge 1
        checks++; if (data_out !== 4'hA) begin errors++; $display("FAIL rmp_data1 got %h exp a", data_out); end
        repeat (2) tick();  // edge 3
        checks++; if (strobe !== 2'b11) begin errors++; $display("FAIL rmp_strobe3 got %b exp 11", strobe); end
        repeat (2) tick();  // edge 5
        checks++; if (strobe !== 2'b00) begin errors++; $display("FAIL rmp_strobe5 got %b exp 00", strobe); end
        tick();  // edge 6
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmp_no_replay got busy %b exp 0", busy); end
        checks++; if (shadow_state !== exp_sh) begin errors++; $display("FAIL rmp_shadow6 got %h exp %h", shadow_state, exp_sh); end
    endtask

    task automatic test_wrap();
        int push_at[5] = '{0, 1, 2, 6, 11};
        int k = 0;
        logic [1:0] prev_strobe = 2'b00;
        int rise_dat[$];
        do_reset();
        for (int c = 0; c < 40; c++) begin
            cmd_valid = (k < 5) && (push_at[k] == c);
            cmd_data  = 4'(k + 8);
            cmd_lane  = 2'b01;
            #1;
            if (cmd_valid && cmd_ready) k++;
            tick();
            if ((c == 6) || (c == 11)) begin
                checks++;
                if (fifo_count !== 3'd2) begin errors++; $display("FAIL wrap_count edge %0d got %0d exp 2", c, fifo_count); end
            end
            if ((prev_strobe == 2'b00) && (strobe != 2'b00)) rise_dat.push_back(int'(data_out));
            prev_strobe = strobe;
        end
        cmd_valid = 1'b0;
        checks++; if (rise_dat.size() != 5) begin errors++; $display("FAIL wrap_pulses got %0d exp 5", rise_dat.size()); end
        for (int i = 0; i < rise_dat.size(); i++) begin
            checks++;
            if (rise_dat[i] != i + 8) begin errors++; $display("FAIL wrap_order idx %0d got %h exp %h", i, rise_dat[i], i + 8); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_shadow();
        test_lane_zero();
        test_reset_mid_pulse();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
